// File: rtl/saw_pkg.sv
// Shared definitions for the stop-and-wait retransmit controller:
// FSM state encoding, ack_code bit positions and frame width helper.
package saw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    FAIL = 2'd3
  } saw_state_e;

  // ack_code layout: [2]=ack frame CRC good, [1]=acked seq, [0]=1 ACK / 0 NAK
  localparam int unsigned ACK_OK_B    = 2;
  localparam int unsigned ACK_SEQ_B   = 1;
  localparam int unsigned ACK_ISACK_B = 0;

  // Frame is {seq, payload, crc}
  function automatic int unsigned FRAME_BW(input int unsigned payload_bw,
                                           input int unsigned crc_bw);
    return 1 + payload_bw + crc_bw;
  endfunction

endpackage

// File: rtl/saw_timeout_timer.sv
// Saturating ACK timeout timer: cleared while not waiting, counts while
// enabled, flags expiry when the count reaches TIMEOUT-1.
module saw_timeout_timer #(
  parameter int unsigned CNT_BW  = 5,
  parameter int unsigned TIMEOUT = 20
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [CNT_BW-1:0] cnt_q, cnt_d;

  // Next count: clear has priority, increment stops at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_BW'(1);
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CNT_BW'(TIMEOUT - 1));

endmodule

// File: rtl/saw_retx_controller.sv
// Stop-and-wait ARQ transmit sequencer: latches {seq,payload,crc}, offers it
// to the link, waits for ACK under a timeout and retransmits on NAK/timeout
// up to MAX_RETRY times before entering FAIL.
// Optional statistics counters are enabled with SAW_CTRL_STATS_EN.
module saw_retx_controller
  import saw_pkg::*;
#(
  parameter int unsigned PAYLOAD_BW = 10,
  parameter int unsigned CRC_BW     = 8,
  parameter int unsigned ACK_BW     = 3,
  parameter int unsigned CNT_BW     = 5,
  parameter int unsigned TIMEOUT    = 20,
  parameter int unsigned RTY_BW     = 2,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           pl_valid,
  output logic                           pl_ready,
  input  logic [PAYLOAD_BW-1:0]          pl_data,
  input  logic [CRC_BW-1:0]              crc_in,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [PAYLOAD_BW+CRC_BW:0]     tx_frame,
  input  logic                           ack_valid,
  input  logic [ACK_BW-1:0]              ack_code,
  input  logic                           clear_fail,
  output logic                           done,
  output logic                           fail,
  output logic                           seq_o,
  output logic [RTY_BW-1:0]              retry_cnt
`ifdef SAW_CTRL_STATS_EN
  ,
  output logic [15:0]                    stat_frames,
  output logic [15:0]                    stat_retx,
  output logic [7:0]                     stat_fails
`endif
);

  localparam int unsigned FW = FRAME_BW(PAYLOAD_BW, CRC_BW);

  saw_state_e        state_q, state_d;
  logic              seq_q, seq_d;
  logic [RTY_BW-1:0] retry_q, retry_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic              done_q, done_d;
  logic              expire;
  logic              ack_good, ack_match, nak;
  logic              ev_ack, ev_retx, ev_fail;

  saw_timeout_timer #(
    .CNT_BW  (CNT_BW),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .clr_i    (state_q != WAIT),
    .en_i     (state_q == WAIT),
    .expire_o (expire)
  );

  assign ack_good  = ack_valid & ack_code[ACK_OK_B];
  assign ack_match = ack_good & ack_code[ACK_ISACK_B] & (ack_code[ACK_SEQ_B] == seq_q);
  assign nak       = ack_good & ~ack_code[ACK_ISACK_B];

  // Next-state, frame/seq/retry updates and event strobes
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    retry_d = retry_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    ev_ack  = 1'b0;
    ev_retx = 1'b0;
    ev_fail = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pl_valid) begin
          frame_d = {seq_q, pl_data, crc_in};
          retry_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Matching ACK is checked first so it beats a simultaneous timeout
        if (ack_match) begin
          seq_d   = ~seq_q;
          done_d  = 1'b1;
          ev_ack  = 1'b1;
          state_d = IDLE;
        end else if (nak || expire) begin
          if (retry_q == RTY_BW'(MAX_RETRY)) begin
            ev_fail = 1'b1;
            state_d = FAIL;
          end else begin
            retry_d = retry_q + RTY_BW'(1);
            ev_retx = 1'b1;
            state_d = SEND;
          end
        end
      end
      FAIL: begin
        if (clear_fail) begin
          retry_d = '0;
          frame_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and data registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      seq_q   <= 1'b0;
      retry_q <= '0;
      frame_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      retry_q <= retry_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  assign pl_ready  = (state_q == IDLE);
  assign tx_valid  = (state_q == SEND);
  assign fail      = (state_q == FAIL);
  assign tx_frame  = frame_q;
  assign done      = done_q;
  assign seq_o     = seq_q;
  assign retry_cnt = retry_q;

`ifdef SAW_CTRL_STATS_EN
  logic [15:0] frames_q, retx_q;
  logic [7:0]  fails_q;

  // Saturating event counters, bumped on the edge that takes the event
  always_ff @(posedge clk) begin
    if (!rstn) begin
      frames_q <= '0;
      retx_q   <= '0;
      fails_q  <= '0;
    end else begin
      if (ev_ack  && (frames_q != '1)) frames_q <= frames_q + 16'd1;
      if (ev_retx && (retx_q   != '1)) retx_q   <= retx_q + 16'd1;
      if (ev_fail && (fails_q  != '1)) fails_q  <= fails_q + 8'd1;
    end
  end

  assign stat_frames = frames_q;
  assign stat_retx   = retx_q;
  assign stat_fails  = fails_q;
`else
  logic unused_ev;
  assign unused_ev = ev_ack | ev_retx | ev_fail;
`endif

endmodule
